// File: rtl/pll_lock_pkg.sv
// Purpose: shared state encoding and timer sizing helper for the PLL lock sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_lock_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILISE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  // One timer serves both the stabilise and hold phases, so size it for the longer one.
  function automatic int tm_width(input int stable_cycles, input int rst_hold);
    int m;
    m = (stable_cycles > rst_hold) ? stable_cycles : rst_hold;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: single-bit two-flop synchroniser with synchronous clear.
// Latency: 2 clk cycles from input sample to output.
// Backpressure: none; free-running.
module sync_2ff (
  input  logic clk,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of an asynchronous input; clear forces both stages low.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Purpose: qualify PLL lock, sequence video reset/enable, filter and count lock losses.
// Latency: reset release STABLE_CYCLES+2 after lock sampled, enable RST_HOLD later; loss reacts LOSS_FILTER+1 after drop.
// Backpressure: none; runs on the free-running board clock.
module pll_lock_sequencer
  import pll_lock_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int RST_HOLD      = 16,
  parameter int LOSS_FILTER   = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked_i,
  input  logic             clear_i,
  output logic             rst_video_o,
  output logic             video_en_o,
  output logic [CNT_W-1:0] lock_loss_cnt_o,
  output logic             lock_lost_sticky_o,
  output logic [1:0]       state_o
);

  localparam int TM_W = tm_width(STABLE_CYCLES, RST_HOLD);
  localparam int LF_W = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;
  localparam logic [TM_W-1:0] TM_STAB_END = TM_W'(STABLE_CYCLES - 1);
  localparam logic [TM_W-1:0] TM_HOLD_END = TM_W'(RST_HOLD - 1);
  localparam logic [LF_W-1:0] LF_END      = LF_W'(LOSS_FILTER - 1);

  logic             locked_s;
  state_e           state_q, state_d;
  logic [TM_W-1:0]  tm_q, tm_d;
  logic [LF_W-1:0]  lf_q, lf_d;
  logic             rst_video_q, rst_video_d;
  logic             video_en_q, video_en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             loss_evt;

  sync_2ff u_sync_lock (
    .clk   (clk),
    .clr_i (rst),
    .d_i   (pll_locked_i),
    .q_o   (locked_s)
  );

  // State, shared timer, loss filter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_LOCK;
      tm_q        <= '0;
      lf_q        <= '0;
      rst_video_q <= 1'b1;
      video_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tm_q        <= tm_d;
      lf_q        <= lf_d;
      rst_video_q <= rst_video_d;
      video_en_q  <= video_en_d;
    end
  end

  // Next-state: qualify lock, time the hold, and detect filtered losses (loss beats HOLD->RUN).
  always_comb begin
    state_d  = state_q;
    tm_d     = tm_q;
    lf_d     = '0;
    loss_evt = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        tm_d = '0;
        if (locked_s) state_d = STABILISE;
      end
      STABILISE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          tm_d    = '0;
        end else if (tm_q == TM_STAB_END) begin
          state_d = HOLD;
          tm_d    = '0;
        end else begin
          tm_d = tm_q + TM_W'(1);
        end
      end
      HOLD, RUN: begin
        if (!locked_s) begin
          if (lf_q == LF_END) begin
            loss_evt = 1'b1;
            state_d  = WAIT_LOCK;
            tm_d     = '0;
          end else begin
            lf_d = lf_q + LF_W'(1);
          end
        end
        if (!loss_evt && state_q == HOLD) begin
          if (tm_q == TM_HOLD_END) begin
            state_d = RUN;
            tm_d    = '0;
          end else begin
            tm_d = tm_q + TM_W'(1);
          end
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        tm_d    = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so the registered copies track state_q exactly.
  always_comb begin
    rst_video_d = (state_d == WAIT_LOCK) || (state_d == STABILISE);
    video_en_d  = (state_d == RUN);
  end

  // Loss counter and sticky flag; a loss in the same cycle as clear leaves a count of one.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (loss_evt) begin
      sticky_d = 1'b1;
      if (clear_i)           cnt_d = CNT_W'(1);
      else if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (clear_i) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
  end

  // Debug counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign rst_video_o        = rst_video_q;
  assign video_en_o         = video_en_q;
  assign lock_loss_cnt_o    = cnt_q;
  assign lock_lost_sticky_o = sticky_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Purpose: directed self-checking bench for pll_lock_sequencer.
// Latency: checks exact edge-by-edge timing of lock-up, loss and clear.
// Backpressure: n/a.
module tb_pll_lock_sequencer;

  localparam int S  = 8;
  localparam int R  = 4;
  localparam int L  = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pll_locked_i;
  logic          clear_i;
  logic          rst_video_o;
  logic          video_en_o;
  logic [CW-1:0] lock_loss_cnt_o;
  logic          lock_lost_sticky_o;
  logic [1:0]    state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .STABLE_CYCLES (S),
    .RST_HOLD      (R),
    .LOSS_FILTER   (L),
    .CNT_W         (CW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .pll_locked_i       (pll_locked_i),
    .clear_i            (clear_i),
    .rst_video_o        (rst_video_o),
    .video_en_o         (video_en_o),
    .lock_loss_cnt_o    (lock_loss_cnt_o),
    .lock_lost_sticky_o (lock_lost_sticky_o),
    .state_o            (state_o)
  );

  // Advance n active edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lock_to_run();
    pll_locked_i = 1'b1;
    tick(16);
  endtask

  task automatic do_loss();
    pll_locked_i = 1'b0;
    tick(5);
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked_i = 1'b0; clear_i = 1'b0;
    tick(3);
    n_checks++; if (rst_video_o !== 1'b1) begin n_fail++; $display("FAIL reset_rst_video: got %b exp 1", rst_video_o); end
    n_checks++; if (video_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_video_en: got %b exp 0", video_en_o); end
    n_checks++; if (lock_loss_cnt_o !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d exp 0", lock_loss_cnt_o); end
    n_checks++; if (lock_lost_sticky_o !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b exp 0", lock_lost_sticky_o); end
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", state_o); end
    rst = 1'b0;
    tick(2);
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_idle_state: got %0d exp 0", state_o); end
  endtask

  task automatic test_lockup();
    pll_locked_i = 1'b1;  // first sampled at edge t
    tick(2);  // after t+1
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL lockup_state_t1: got %0d exp 0", state_o); end
    tick(1);  // after t+2
    n_checks++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL lockup_state_t2: got %0d exp 1", state_o); end
    tick(7);  // after t+9
    n_checks++; if (rst_video_o !== 1'b1) begin n_fail++; $display("FAIL lockup_rst_t9: got %b exp 1", rst_video_o); end
    tick(1);  // after t+10
    n_checks++; if (rst_video_o !== 1'b0) begin n_fail++; $display("FAIL lockup_rst_t10: got %b exp 0", rst_video_o); end
    n_checks++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL lockup_state_t10: got %0d exp 2", state_o); end
    tick(3);  // after t+13
    n_checks++; if (video_en_o !== 1'b0) begin n_fail++; $display("FAIL lockup_en_t13: got %b exp 0", video_en_o); end
    tick(1);  // after t+14
    n_checks++; if (video_en_o !== 1'b1) begin n_fail++; $display("FAIL lockup_en_t14: got %b exp 1", video_en_o); end
    n_checks++; if (state_o !== 2'd3) begin n_fail++; $display("FAIL lockup_state_t14: got %0d exp 3", state_o); end
  endtask

  task automatic test_glitch();
    pll_locked_i = 1'b0;
    tick(2);
    pll_locked_i = 1'b1;
    tick(6);
    n_checks++; if (state_o !== 2'd3) begin n_fail++; $display("FAIL glitch_state: got %0d exp 3", state_o); end
    n_checks++; if (video_en_o !== 1'b1) begin n_fail++; $display("FAIL glitch_en: got %b exp 1", video_en_o); end
    n_checks++; if (lock_loss_cnt_o !== 4'd0) begin n_fail++; $display("FAIL glitch_cnt: got %0d exp 0", lock_loss_cnt_o); end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1; pll_locked_i = 1'b0;
    tick(1);
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL midrst_state: got %0d exp 0", state_o); end
    n_checks++; if (rst_video_o !== 1'b1) begin n_fail++; $display("FAIL midrst_rst_video: got %b exp 1", rst_video_o); end
    n_checks++; if (video_en_o !== 1'b0) begin n_fail++; $display("FAIL midrst_en: got %b exp 0", video_en_o); end
    n_checks++; if (lock_loss_cnt_o !== 4'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d exp 0", lock_loss_cnt_o); end
    n_checks++; if (lock_lost_sticky_o !== 1'b0) begin n_fail++; $display("FAIL midrst_sticky: got %b exp 0", lock_lost_sticky_o); end
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_early_drop();
    pll_locked_i = 1'b1;
    tick(5);
    n_checks++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL early_in_stab: got %0d exp 1", state_o); end
    pll_locked_i = 1'b0;  // sampled at edge v
    tick(1);
    pll_locked_i = 1'b1;  // sampled at edge v+1
    tick(1);
    n_checks++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL early_state_v1: got %0d exp 1", state_o); end
    tick(1);
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL early_state_v2: got %0d exp 0", state_o); end
    n_checks++; if (lock_loss_cnt_o !== 4'd0) begin n_fail++; $display("FAIL early_cnt: got %0d exp 0", lock_loss_cnt_o); end
    tick(1);
    n_checks++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL early_state_v3: got %0d exp 1", state_o); end
    tick(7);
    n_checks++; if (rst_video_o !== 1'b1) begin n_fail++; $display("FAIL early_rst_v10: got %b exp 1", rst_video_o); end
    tick(1);
    n_checks++; if (rst_video_o !== 1'b0) begin n_fail++; $display("FAIL early_rst_v11: got %b exp 0", rst_video_o); end
    tick(4);
    n_checks++; if (video_en_o !== 1'b1) begin n_fail++; $display("FAIL early_en_v15: got %b exp 1", video_en_o); end
    n_checks++; if (lock_lost_sticky_o !== 1'b0) begin n_fail++; $display("FAIL early_sticky: got %b exp 0", lock_lost_sticky_o); end
  endtask

  task automatic test_loss();
    pll_locked_i = 1'b0;  // sampled at edge u
    tick(4);  // after u+3
    n_checks++; if (state_o !== 2'd3) begin n_fail++; $display("FAIL loss_state_u3: got %0d exp 3", state_o); end
    n_checks++; if (video_en_o !== 1'b1) begin n_fail++; $display("FAIL loss_en_u3: got %b exp 1", video_en_o); end
    tick(1);  // after u+4
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL loss_state_u4: got %0d exp 0", state_o); end
    n_checks++; if (rst_video_o !== 1'b1) begin n_fail++; $display("FAIL loss_rst_u4: got %b exp 1", rst_video_o); end
    n_checks++; if (video_en_o !== 1'b0) begin n_fail++; $display("FAIL loss_en_u4: got %b exp 0", video_en_o); end
    n_checks++; if (lock_loss_cnt_o !== 4'd1) begin n_fail++; $display("FAIL loss_cnt: got %0d exp 1", lock_loss_cnt_o); end
    n_checks++; if (lock_lost_sticky_o !== 1'b1) begin n_fail++; $display("FAIL loss_sticky: got %b exp 1", lock_lost_sticky_o); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 16; i++) begin
      lock_to_run();
      do_loss();
      if (i == 12) begin
        n_checks++; if (lock_loss_cnt_o !== 4'd14) begin n_fail++; $display("FAIL sat_cnt14: got %0d exp 14", lock_loss_cnt_o); end
      end
    end
    n_checks++; if (lock_loss_cnt_o !== 4'd15) begin n_fail++; $display("FAIL sat_cnt: got %0d exp 15", lock_loss_cnt_o); end
    n_checks++; if (lock_lost_sticky_o !== 1'b1) begin n_fail++; $display("FAIL sat_sticky: got %b exp 1", lock_lost_sticky_o); end
  endtask

  task automatic test_reset_clears();
    lock_to_run();
    test_mid_reset();
  endtask

  task automatic test_clear_collision();
    for (int i = 0; i < 5; i++) begin
      lock_to_run();
      do_loss();
    end
    n_checks++; if (lock_loss_cnt_o !== 4'd5) begin n_fail++; $display("FAIL clr_pre_cnt: got %0d exp 5", lock_loss_cnt_o); end
    lock_to_run();
    pll_locked_i = 1'b0;  // loss lands on edge u+4
    tick(4);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    n_checks++; if (lock_loss_cnt_o !== 4'd1) begin n_fail++; $display("FAIL clr_coll_cnt: got %0d exp 1", lock_loss_cnt_o); end
    n_checks++; if (lock_lost_sticky_o !== 1'b1) begin n_fail++; $display("FAIL clr_coll_sticky: got %b exp 1", lock_lost_sticky_o); end
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL clr_coll_state: got %0d exp 0", state_o); end
    lock_to_run();
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    n_checks++; if (lock_loss_cnt_o !== 4'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d exp 0", lock_loss_cnt_o); end
    n_checks++; if (lock_lost_sticky_o !== 1'b0) begin n_fail++; $display("FAIL clr_sticky: got %b exp 0", lock_lost_sticky_o); end
    n_checks++; if (state_o !== 2'd3) begin n_fail++; $display("FAIL clr_state: got %0d exp 3", state_o); end
    tick(2);
    n_checks++; if (video_en_o !== 1'b1) begin n_fail++; $display("FAIL clr_en: got %b exp 1", video_en_o); end
  endtask

  initial begin
    rst = 1'b1;
    pll_locked_i = 1'b0;
    clear_i = 1'b0;
    test_reset();
    test_lockup();
    test_glitch();
    test_mid_reset();
    test_early_drop();
    test_loss();
    test_saturation();
    test_reset_clears();
    test_clear_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
